relogio_ajuste_ctrl: RTL and testbench
======================================

Name: relogio_ajuste_ctrl

Overview:
Button-driven mode and time-setting controller for the 24 h HH:MM:SS BCD clock core.
- Cycles the display between main time and alternate time.
- Runs a set-hours, then set-minutes edit sequence.
- Drives the core's H_in1/H_in0/M_in1/M_in0 load bus and issues a single-cycle LD_time pulse to commit the edited time.
- Sits between the debounced panel buttons and the clock core; seeds its edit registers from the core's live H/M outputs.

Parameters:
BLINK_DIV, 25_000_000, clock cycles per half-period of the edit-digit blink signal (minimum 2).
TIMEOUT_CYC, 500_000_000, idle cycles before an abandoned edit is discarded (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_mode  in  1  debounced mode button (level; rising edge = press)
btn_inc  in  1  debounced increment button (level; rising edge = press)
cur_H1  in  2  live hour tens from clock core
cur_H0  in  4  live hour units
cur_M1  in  4  live minute tens
cur_M0  in  4  live minute units
H_in1  out  2  edited hour tens to core
H_in0  out  4  edited hour units
M_in1  out  4  edited minute tens
M_in0  out  4  edited minute units
LD_time  out  1  one-cycle load strobe to core
display_modo  out  2  00 main, 01 alternate, 10 edit hours, 11 edit minutes
blink  out  1  digit blink enable for the display driver

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - State is RUN.
  - H_in1/H_in0/M_in1/M_in0 = 0.
  - LD_time = 0, display_modo = 00, blink = 0.
  - Button history registers = 1, so a button held through reset is not counted as a press.
  - Blink counter = 0.
- Press detection: press = btn & ~btn_q, with btn_q registered every cycle. The press acts on the same clock edge at which it is detected.
- FSM states: RUN, ALT, SET_H, SET_M, LOAD.
  - RUN --mode--> ALT.
  - ALT --mode--> SET_H. On this transition, edit registers capture cur_H1/H0/M1/M0 sampled at that edge.
  - SET_H --mode--> SET_M.
  - SET_M --mode--> LOAD.
  - LOAD --> RUN unconditionally after one cycle.
- LD_time is 1 only while in LOAD: exactly one cycle, one cycle after the last mode press. The load bus holds the edited value in LOAD and keeps it afterwards.
- Increment in SET_H (BCD, wraps):
  - 23 -> 00.
  - x9 -> (x+1)0.
  - Otherwise units + 1.
- Increment in SET_M (BCD, wraps):
  - M0 == 9: M0 = 0, and M1 becomes 0 if it was 5, else M1 + 1.
  - Otherwise M0 + 1. This gives 59 -> 00.
- Increment presses in RUN, ALT or LOAD are ignored.
- Simultaneous mode and inc presses: mode wins; inc is discarded that cycle.
- display_modo is decoded from state: RUN=00, ALT=01, SET_H=10, SET_M=11, LOAD=00.
- Blink:
  - In SET_H or SET_M, blink toggles every BLINK_DIV cycles.
  - The counter and blink clear to 0 on every state change and in all other states.
  - An inc press also clears the counter and forces blink = 0, so the digit shows solid while adjusting.
- Reset mid-edit: returns to RUN with no LD_time pulse; edit contents are discarded (zeroed).
- Edit registers never hold invalid BCD. Seed values are assumed valid from the core and are not range-checked.

Optional Feature:
Macro RELOGIO_AJUSTE_TIMEOUT_EN.
- Defined: an idle counter runs in SET_H and SET_M and clears on any press. On reaching TIMEOUT_CYC the FSM returns to RUN with no LD_time, and the core keeps its running time.
- Undefined: no counter is instantiated and the edit states persist indefinitely.

Decomposition:
- Shared package relogio_pkg holds:
  - the state enum (RUN, ALT, SET_H, SET_M, LOAD);
  - the display_modo encodings;
  - the BCD limit constants HOUR_MAX_T=2, HOUR_MAX_U=3, MIN_MAX_T=5, DIGIT_MAX=9.
- One sub-module: relogio_bcd_inc, a combinational BCD increment with a mode input (hours or minutes) returning the wrapped two-digit value. It is instantiated once and shared by both edit states.

Test Plan:
- Reset asserted 3 cycles with btn_mode held high, then released while still held -> no transition; state RUN, display_modo=00, LD_time=0.
- Core at 12:34; press mode twice -> display_modo=10 and H_in=12, M_in=34. Press mode twice more -> exactly one LD_time cycle with H_in=12, M_in=34, then display_modo=00.
- In SET_H from 22, press inc twice -> 23 then 00. In SET_M from 58, press inc twice -> 59 then 00. Hour tens never exceeds 2; minute tens never exceeds 5.
- btn_mode and btn_inc rise in the same cycle in SET_H -> state becomes SET_M and the hour is unchanged.
- Assert reset while in SET_M with edited 09:15 -> RUN, all outputs zero, no LD_time ever asserted.
- With BLINK_DIV=4, in SET_H: blink toggles every 4 cycles; an inc press forces blink=0 and restarts the count. With RELOGIO_AJUSTE_TIMEOUT_EN and TIMEOUT_CYC=20: 20 idle cycles in SET_M -> RUN with no LD_time.

Source files
------------

// File: rtl/relogio_pkg.sv
// rtl/relogio_pkg.sv - shared states, display codes and BCD limits for the clock setting controller
package relogio_pkg;

  typedef enum logic [2:0] {
    RUN,
    ALT,
    SET_H,
    SET_M,
    LOAD
  } state_t;

  localparam logic [1:0] DISP_MAIN  = 2'b00;
  localparam logic [1:0] DISP_ALT   = 2'b01;
  localparam logic [1:0] DISP_SET_H = 2'b10;
  localparam logic [1:0] DISP_SET_M = 2'b11;

  localparam logic [3:0] HOUR_MAX_T = 4'd2;
  localparam logic [3:0] HOUR_MAX_U = 4'd3;
  localparam logic [3:0] MIN_MAX_T  = 4'd5;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

endpackage

// File: rtl/relogio_ajuste_ctrl_if.sv
// rtl/relogio_ajuste_ctrl_if.sv - panel buttons, live core time and load bus between panel/core and controller
interface relogio_ajuste_ctrl_if;

  logic       btn_mode;
  logic       btn_inc;
  logic [1:0] cur_H1;
  logic [3:0] cur_H0;
  logic [3:0] cur_M1;
  logic [3:0] cur_M0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic [1:0] display_modo;
  logic       blink;

  modport master (
    output btn_mode, btn_inc, cur_H1, cur_H0, cur_M1, cur_M0,
    input  H_in1, H_in0, M_in1, M_in0, LD_time, display_modo, blink
  );

  modport slave (
    input  btn_mode, btn_inc, cur_H1, cur_H0, cur_M1, cur_M0,
    output H_in1, H_in0, M_in1, M_in0, LD_time, display_modo, blink
  );

endinterface

// File: rtl/relogio_bcd_inc.sv
// rtl/relogio_bcd_inc.sv - two-digit BCD increment, wrapping at 23 (hours) or 59 (minutes)
module relogio_bcd_inc
  import relogio_pkg::*;
(
  input  logic       min_mode,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [3:0] tens_nxt,
  output logic [3:0] units_nxt
);

  always_comb begin
    tens_nxt  = tens;
    units_nxt = units + 4'd1;
    if (units == DIGIT_MAX) begin
      units_nxt = 4'd0;
      tens_nxt  = tens + 4'd1;
      if (min_mode && tens == MIN_MAX_T) begin
        tens_nxt = 4'd0;
      end
    end
    if (!min_mode && tens == HOUR_MAX_T && units == HOUR_MAX_U) begin
      tens_nxt  = 4'd0;
      units_nxt = 4'd0;
    end
  end

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// rtl/relogio_ajuste_ctrl.sv - mode/time-setting FSM driving the clock core load bus
// Optional edit-abandon timeout: RELOGIO_AJUSTE_TIMEOUT_EN.
module relogio_ajuste_ctrl
  import relogio_pkg::*;
#(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  relogio_ajuste_ctrl_if.slave  bus
);

  localparam int BW = $clog2(BLINK_DIV);

  state_t        state_q, state_d;
  logic          mode_q, inc_q;
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          press_mode, press_inc_raw, press_inc;
  logic          in_edit, timeout_hit;
  logic          min_mode;
  logic [3:0]    inc_t_in, inc_u_in, inc_t, inc_u;

  assign press_mode    = bus.btn_mode & ~mode_q;
  assign press_inc_raw = bus.btn_inc & ~inc_q;
  assign press_inc     = press_inc_raw & ~press_mode;
  assign in_edit       = (state_q == SET_H) || (state_q == SET_M);

  // One incrementer serves both edit states; the state picks which pair it sees.
  assign min_mode = (state_q == SET_M);
  assign inc_t_in = min_mode ? m1_q : {2'b00, h1_q};
  assign inc_u_in = min_mode ? m0_q : h0_q;

  relogio_bcd_inc u_bcd_inc (
    .min_mode  (min_mode),
    .tens      (inc_t_in),
    .units     (inc_u_in),
    .tens_nxt  (inc_t),
    .units_nxt (inc_u)
  );

`ifdef RELOGIO_AJUSTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] idle_q;
  logic          any_press;

  assign any_press   = press_mode | press_inc_raw;
  assign timeout_hit = in_edit && !any_press && (idle_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
    end else if (in_edit && !any_press) begin
      idle_q <= idle_q + 1'b1;
    end else begin
      idle_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      mode_q  <= 1'b1;
      inc_q   <= 1'b1;
      h1_q    <= '0;
      h0_q    <= '0;
      m1_q    <= '0;
      m0_q    <= '0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= bus.btn_mode;
      inc_q   <= bus.btn_inc;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    bcnt_d  = '0;
    blink_d = 1'b0;

    case (state_q)
      RUN: begin
        if (press_mode) state_d = ALT;
      end
      ALT: begin
        if (press_mode) begin
          state_d = SET_H;
          h1_d    = bus.cur_H1;
          h0_d    = bus.cur_H0;
          m1_d    = bus.cur_M1;
          m0_d    = bus.cur_M0;
        end
      end
      SET_H: begin
        if (press_mode) begin
          state_d = SET_M;
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (press_inc) begin
          h1_d = inc_t[1:0];
          h0_d = inc_u;
        end
      end
      SET_M: begin
        if (press_mode) begin
          state_d = LOAD;
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (press_inc) begin
          m1_d = inc_t;
          m0_d = inc_u;
        end
      end
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase

    // Blink runs only while staying in an edit state; an inc press restarts it dark.
    if (in_edit && state_d == state_q && !press_inc) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        blink_d = blink_q;
      end
    end
  end

  always_comb begin
    bus.display_modo = DISP_MAIN;
    case (state_q)
      ALT:     bus.display_modo = DISP_ALT;
      SET_H:   bus.display_modo = DISP_SET_H;
      SET_M:   bus.display_modo = DISP_SET_M;
      default: bus.display_modo = DISP_MAIN;
    endcase
  end

  assign bus.LD_time = (state_q == LOAD);
  assign bus.blink   = blink_q;
  assign bus.H_in1   = h1_q;
  assign bus.H_in0   = h0_q;
  assign bus.M_in1   = m1_q;
  assign bus.M_in0   = m0_q;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// tb/tb_relogio_ajuste_ctrl.sv - scoreboard bench for relogio_ajuste_ctrl against a time/mode reference model
module tb_relogio_ajuste_ctrl;

  localparam int BD  = 4;
  localparam int TOC = 20;

  localparam int M_RUN = 0, M_ALT = 1, M_SETH = 2, M_SETM = 3, M_LOAD = 4;

  typedef struct packed {
    logic [1:0] disp;
    logic       ld;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic       blink;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  relogio_ajuste_ctrl_if bus ();

  relogio_ajuste_ctrl #(.BLINK_DIV(BD), .TIMEOUT_CYC(TOC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   ld_model = 0;
  int   ld_dut   = 0;
  bit   stim_done = 0;

  // Reference model: edit time kept as plain hour/minute integers.
  int md = M_RUN, eh = 0, em = 0, k = 0, idle = 0;
  bit pm = 1, pi = 1;

  task automatic step(input bit rst, input bit bm, input bit bi, input int ch, input int cm);
    bit   pmode, rinc, pinc, tmo, edit;
    int   old;
    exp_t e;
    reset        = rst;
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    bus.cur_H1   = 2'(ch / 10);
    bus.cur_H0   = 4'(ch % 10);
    bus.cur_M1   = 4'(cm / 10);
    bus.cur_M0   = 4'(cm % 10);
    if (rst) begin
      md = M_RUN; eh = 0; em = 0; k = 0; idle = 0; pm = 1; pi = 1;
    end else begin
      pmode = bm && !pm;
      rinc  = bi && !pi;
      pinc  = rinc && !pmode;
      pm = bm;
      pi = bi;
      edit = (md == M_SETH || md == M_SETM);
      old  = md;
      tmo  = 0;
      if (edit && !pmode && !rinc) idle++;
      else idle = 0;
`ifdef RELOGIO_AJUSTE_TIMEOUT_EN
      tmo = (idle >= TOC);
`endif
      case (md)
        M_RUN:  if (pmode) md = M_ALT;
        M_ALT:  if (pmode) begin md = M_SETH; eh = ch; em = cm; end
        M_SETH: if (pmode) md = M_SETM; else if (tmo) md = M_RUN; else if (pinc) eh = (eh + 1) % 24;
        M_SETM: if (pmode) md = M_LOAD; else if (tmo) md = M_RUN; else if (pinc) em = (em + 1) % 60;
        default: md = M_RUN;
      endcase
      if ((md == M_SETH || md == M_SETM) && md == old && !pinc) k++;
      else k = 0;
    end
    e.disp  = (md == M_ALT) ? 2'b01 : (md == M_SETH) ? 2'b10 : (md == M_SETM) ? 2'b11 : 2'b00;
    e.ld    = (md == M_LOAD);
    e.h1    = 2'(eh / 10);
    e.h0    = 4'(eh % 10);
    e.m1    = 4'(em / 10);
    e.m0    = 4'(em % 10);
    e.blink = (md == M_SETH || md == M_SETM) ? (((k / BD) % 2) != 0) : 1'b0;
    if (e.ld) ld_model++;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit bm, input bit bi, input int ch, input int cm);
    @(negedge clk);
    step(rst, bm, bi, ch, cm);
  endtask

  task automatic press_mode(input int ch, input int cm);
    cyc(0, 1, 0, ch, cm);
    cyc(0, 0, 0, ch, cm);
  endtask

  task automatic press_inc(input int ch, input int cm);
    cyc(0, 0, 1, ch, cm);
    cyc(0, 0, 0, ch, cm);
  endtask

  task automatic idle_cycles(input int n, input int ch, input int cm);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, ch, cm);
  endtask

  initial begin
    step(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    press_mode(12, 34);
    press_mode(12, 34);
    press_mode(12, 34);
    press_mode(12, 34);
    idle_cycles(3, 12, 34);

    press_mode(22, 58);
    press_mode(22, 58);
    press_inc(22, 58);
    press_inc(22, 58);
    press_mode(22, 58);
    press_inc(22, 58);
    press_inc(22, 58);
    press_mode(22, 58);
    idle_cycles(2, 22, 58);

    press_mode(7, 5);
    press_mode(7, 5);
    cyc(0, 1, 1, 7, 5);
    cyc(0, 0, 0, 7, 5);
    press_mode(7, 5);
    idle_cycles(2, 7, 5);

    press_mode(9, 15);
    press_mode(9, 15);
    press_mode(9, 15);
    idle_cycles(2, 9, 15);
    cyc(1, 0, 0, 9, 15);
    idle_cycles(3, 9, 15);

    press_mode(19, 9);
    press_mode(19, 9);
    idle_cycles(11, 19, 9);
    press_inc(19, 9);
    idle_cycles(10, 19, 9);
    press_mode(19, 9);
    idle_cycles(25, 19, 9);
    cyc(1, 0, 0, 0, 0);

    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
    end
    stim_done = 1;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (bus.LD_time === 1'b1) ld_dut++;
      if (exp_q.size() == 0) begin
        if (!stim_done) begin
          errors++;
          checks++;
          $display("FAIL no_expectation cycle %0d: scoreboard empty", cycle);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (bus.display_modo !== e.disp || bus.LD_time !== e.ld) begin
          errors++;
          $display("FAIL mode_ld cycle %0d: got modo=%b ld=%b expected modo=%b ld=%b",
                   cycle, bus.display_modo, bus.LD_time, e.disp, e.ld);
        end
        checks++;
        if ({bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0} !== {e.h1, e.h0, e.m1, e.m0}) begin
          errors++;
          $display("FAIL load_bus cycle %0d: got %0d%0d:%0d%0d expected %0d%0d:%0d%0d", cycle,
                   bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0, e.h1, e.h0, e.m1, e.m0);
        end
        checks++;
        if (bus.blink !== e.blink) begin
          errors++;
          $display("FAIL blink cycle %0d: got %b expected %b", cycle, bus.blink, e.blink);
        end
      end
    end
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0", stim_done, exp_q.size());
    end
    checks++;
    if (ld_dut != ld_model) begin
      errors++;
      $display("FAIL ld_count: got %0d pulses expected %0d", ld_dut, ld_model);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
